// File: rtl/iq_pattern_checker.sv
// IQ stream checker: verifies both lanes count up by one per accepted sample,
// tracks lock, counts samples/errors and drives a periodic back-pressure pattern.
module iq_pattern_checker #(
   parameter int IQ_W         = 12,
   parameter int CNT_W        = 32,
   parameter int LOCK_COUNT   = 4,
   parameter int LOSS_COUNT   = 3,
   parameter int READY_PERIOD = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [2*IQ_W-1:0] in_data,
   output logic              in_ready,
   input  logic              clear,
   output logic              locked,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [CNT_W-1:0]  error_cnt,
   output logic              err_pulse
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(LOSS_COUNT + 1);
   localparam int RW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

   localparam logic [GW-1:0] G_LOCK = GW'(LOCK_COUNT);
   localparam logic [BW-1:0] B_LOSS = BW'(LOSS_COUNT);
   localparam logic [RW-1:0] R_LAST =
      RW'((READY_PERIOD > 0) ? READY_PERIOD - 1 : 0);

   typedef enum logic {
      S_SEARCH,
      S_LOCKED
   } state_t;

   state_t              state_q, state_d;
   logic                has_prev_q, has_prev_d;
   logic [2*IQ_W-1:0]   prev_q, prev_d;
   logic [GW-1:0]       good_q, good_d;
   logic [BW-1:0]       bad_q, bad_d;
   logic [CNT_W-1:0]    smp_q, smp_d;
   logic [CNT_W-1:0]    err_q, err_d;
   logic                pulse_q, pulse_d;
   logic [RW-1:0]       rcnt_q, rcnt_d;
   logic                rdy_q, rdy_d;

   logic                accept;
   logic                match;
   logic                err_inc;
   logic [IQ_W-1:0]     exp_i, exp_q;
   logic [GW-1:0]       good_inc;
   logic [BW-1:0]       bad_inc;

   assign accept   = in_valid & rdy_q;
   assign exp_i    = prev_q[2*IQ_W-1:IQ_W] + IQ_W'(1);
   assign exp_q    = prev_q[IQ_W-1:0] + IQ_W'(1);
   assign match    = (in_data == {exp_i, exp_q});
   assign good_inc = good_q + GW'(1);
   assign bad_inc  = bad_q + BW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_SEARCH;
         has_prev_q <= 1'b0;
         prev_q     <= '0;
         good_q     <= '0;
         bad_q      <= '0;
         smp_q      <= '0;
         err_q      <= '0;
         pulse_q    <= 1'b0;
         rcnt_q     <= '0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         has_prev_q <= has_prev_d;
         prev_q     <= prev_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         smp_q      <= smp_d;
         err_q      <= err_d;
         pulse_q    <= pulse_d;
         rcnt_q     <= rcnt_d;
         rdy_q      <= rdy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      has_prev_d = has_prev_q;
      prev_d     = prev_q;
      good_d     = good_q;
      bad_d      = bad_q;
      pulse_d    = 1'b0;
      err_inc    = 1'b0;

      if (accept) begin
         unique case (state_q)
            S_SEARCH: begin
               prev_d = in_data;
               if (!has_prev_q) begin
                  has_prev_d = 1'b1;
                  good_d     = '0;
               end else if (!match) begin
                  good_d = '0;
               end else if (good_inc == G_LOCK) begin
                  state_d = S_LOCKED;
                  good_d  = '0;
                  bad_d   = '0;
               end else begin
                  good_d = good_inc;
               end
            end
            S_LOCKED: begin
               if (match) begin
                  bad_d  = '0;
                  prev_d = in_data;
               end else begin
                  // flywheel on the expected value so one bad sample costs one error
                  err_inc = 1'b1;
                  pulse_d = 1'b1;
                  prev_d  = {exp_i, exp_q};
                  bad_d   = bad_inc;
                  if (bad_inc == B_LOSS) begin
                     state_d    = S_SEARCH;
                     has_prev_d = 1'b0;
                     good_d     = '0;
                     bad_d      = '0;
                  end
               end
            end
            default: state_d = S_SEARCH;
         endcase
      end
   end

   always_comb begin
      smp_d = smp_q;
      err_d = err_q;
      if (clear) begin
         smp_d = '0;
         err_d = '0;
      end else begin
         if (accept && !(&smp_q)) smp_d = smp_q + CNT_W'(1);
         if (err_inc && !(&err_q)) err_d = err_q + CNT_W'(1);
      end
   end

   // rdy_d is the ready value for the cycle whose phase is rcnt_q
   always_comb begin
      rdy_d  = 1'b1;
      rcnt_d = '0;
      if (READY_PERIOD > 0) begin
         rdy_d  = (rcnt_q != R_LAST);
         rcnt_d = (rcnt_q == R_LAST) ? '0 : rcnt_q + RW'(1);
      end
   end

   assign in_ready   = rdy_q;
   assign locked     = (state_q == S_LOCKED);
   assign sample_cnt = smp_q;
   assign error_cnt  = err_q;
   assign err_pulse  = pulse_q;

endmodule
